// File: rtl/threadbrain_pkg.sv
// threadbrain_pkg: opcodes, instruction field positions and print FSM states shared by select and execute
package threadbrain_pkg;
  localparam logic [3:0] OP_PLUS  = 4'h1;
  localparam logic [3:0] OP_MINUS = 4'h2;
  localparam logic [3:0] OP_BRZ   = 4'h5;
  localparam logic [3:0] OP_PRINT = 4'h8;
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int IMM_W  = 12;
  typedef enum logic {IDLE, PRINT_WAIT} print_state_e;
  function automatic logic [3:0] opcode(input logic [15:0] i);
    return i[OP_MSB:OP_LSB];
  endfunction
endpackage

// File: rtl/exec_print_if.sv
// exec_print_if: print handshake holder -- FSM, held character and registered stall_out
module exec_print_if
  import threadbrain_pkg::*;
#(
  parameter int PRINT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PRINT_W-1:0] data_in,
  input  logic               print_ready,
  output logic               print_valid,
  output logic [PRINT_W-1:0] print_data,
  output logic               stall_out,
  output logic               done
);
  print_state_e state, next_state;
  always_comb begin
    next_state = (state == IDLE) ? (start ? PRINT_WAIT : IDLE) : (print_ready ? IDLE : PRINT_WAIT);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      print_data <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && start) print_data <= data_in;
    end
  end
  assign print_valid = (state == PRINT_WAIT);
  assign stall_out   = (state == PRINT_WAIT);
  assign done        = print_valid & print_ready;
endmodule

// File: rtl/execute.sv
// execute: PLUS/MINUS write-back, BRZ branch resolution and PRINT handshake.
// Define EXECUTE_RETIRE_CNT_EN to add the retired_cnt output.
module execute
  import threadbrain_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int PRINT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        ins,
  input  logic [DATA_W-1:0]  ptr,
  input  logic [DATA_W-1:0]  val,
  input  logic [DATA_W-1:0]  pc,
  output logic               stall_out,
  output logic               branch_en,
  output logic [DATA_W-1:0]  branch_target,
  output logic               wb_en,
  output logic [DATA_W-1:0]  wb_tag,
  output logic [DATA_W-1:0]  wb_val,
`ifdef EXECUTE_RETIRE_CNT_EN
  output logic [31:0]        retired_cnt,
`endif
  output logic               print_valid,
  output logic [PRINT_W-1:0] print_data,
  input  logic               print_ready
);
  logic [3:0] op;
  logic [IMM_W-1:0] imm;
  logic [DATA_W-1:0] imm_z, imm_s;
  logic cap, is_alu, is_brz, print_done;
  assign op     = opcode(ins);
  assign imm    = ins[IMM_W-1:0];
  assign imm_z  = DATA_W'(imm);
  assign imm_s  = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign cap    = !stall_out;
  assign is_alu = cap && (op == OP_PLUS || op == OP_MINUS);
  assign is_brz = cap && (op == OP_BRZ);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en         <= 1'b0;
      wb_tag        <= '0;
      wb_val        <= '0;
      branch_en     <= 1'b0;
      branch_target <= '0;
    end else begin
      wb_en     <= is_alu;
      branch_en <= is_brz && val == '0;
      if (is_alu) begin
        wb_tag <= ptr;
        wb_val <= (op == OP_PLUS) ? val + imm_z : val - imm_z;
      end
      if (is_brz && val == '0) branch_target <= pc + imm_s;
    end
  end
  exec_print_if #(.PRINT_W(PRINT_W)) u_print (
    .clk(clk),
    .rst_n(rst_n),
    .start(cap && op == OP_PRINT),
    .data_in(val[PRINT_W-1:0]),
    .print_ready(print_ready),
    .print_valid(print_valid),
    .print_data(print_data),
    .stall_out(stall_out),
    .done(print_done)
  );
`ifdef EXECUTE_RETIRE_CNT_EN
  logic brz_done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brz_done    <= 1'b0;
      retired_cnt <= '0;
    end else begin
      brz_done    <= is_brz;
      retired_cnt <= retired_cnt + 32'(wb_en | brz_done | print_done);
    end
  end
`else
  logic unused_done;
  assign unused_done = print_done;
`endif
endmodule

// File: tb/tb_execute.sv
// tb_execute: directed vectors with literal expectations plus a per-cycle model comparison
module tb_execute;
  logic clk = 0, rst_n = 0, print_ready = 0;
  logic [15:0] ins = 0, ptr = 0, val = 0, pc = 0;
  logic stall_out, branch_en, wb_en, print_valid;
  logic [15:0] branch_target, wb_tag, wb_val;
  logic [7:0] print_data;
`ifdef EXECUTE_RETIRE_CNT_EN
  logic [31:0] retired_cnt;
`endif
  int checks = 0, errors = 0;

  execute dut (
    .clk(clk), .rst_n(rst_n), .ins(ins), .ptr(ptr), .val(val), .pc(pc),
    .stall_out(stall_out), .branch_en(branch_en), .branch_target(branch_target),
    .wb_en(wb_en), .wb_tag(wb_tag), .wb_val(wb_val),
`ifdef EXECUTE_RETIRE_CNT_EN
    .retired_cnt(retired_cnt),
`endif
    .print_valid(print_valid), .print_data(print_data), .print_ready(print_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: what each instruction must retire as, one cycle later
  bit m_wb_en, m_br, m_brz_eval, m_pending;
  logic [15:0] m_wb_tag, m_wb_val, m_bt;
  logic [7:0] m_char;
  int m_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wb_en = 0; m_br = 0; m_brz_eval = 0; m_pending = 0; m_cnt = 0;
      m_wb_tag = 0; m_wb_val = 0; m_bt = 0; m_char = 0;
    end else begin
      int imm, off;
      bit hs, accept;
      hs = m_pending && print_ready;
      if (m_wb_en || m_brz_eval || hs) m_cnt++;
      accept = !m_pending;
      m_wb_en = 0; m_br = 0; m_brz_eval = 0;
      imm = int'(ins[11:0]);
      off = (imm >= 2048) ? imm - 4096 : imm;
      if (accept) begin
        case (ins[15:12])
          4'h1: begin m_wb_en = 1; m_wb_tag = ptr; m_wb_val = 16'((int'(val) + imm) % 65536); end
          4'h2: begin m_wb_en = 1; m_wb_tag = ptr; m_wb_val = 16'((int'(val) - imm + 65536) % 65536); end
          4'h5: begin m_brz_eval = 1; m_br = (val == 0); if (m_br) m_bt = 16'((int'(pc) + off + 65536) % 65536); end
          4'h8: begin m_pending = 1; m_char = val[7:0]; end
          default: ;
        endcase
      end
      if (hs) m_pending = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_stall", stall_out, 32'(m_pending));
      chk("m_print_valid", print_valid, 32'(m_pending));
      if (m_pending) chk("m_print_data", print_data, m_char);
      chk("m_wb_en", wb_en, 32'(m_wb_en));
      if (m_wb_en) begin
        chk("m_wb_tag", wb_tag, m_wb_tag);
        chk("m_wb_val", wb_val, m_wb_val);
      end
      chk("m_branch_en", branch_en, 32'(m_br));
      if (m_br) chk("m_branch_target", branch_target, m_bt);
`ifdef EXECUTE_RETIRE_CNT_EN
      chk("m_retired_cnt", retired_cnt, m_cnt);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] i, input logic [15:0] p, input logic [15:0] v, input logic [15:0] c);
    ins = i; ptr = p; val = v; pc = c;
    step();
    ins = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_tag", wb_tag, 0);
    chk("rst_wb_val", wb_val, 0);
    chk("rst_branch_en", branch_en, 0);
    chk("rst_branch_target", branch_target, 0);
    chk("rst_print_valid", print_valid, 0);
    chk("rst_print_data", print_data, 0);
    chk("rst_stall", stall_out, 0);
    rst_n = 1;
    step();
    issue(16'h1003, 16'h0040, 16'h00FE, 0);
    chk("plus_wb_en", wb_en, 1);
    chk("plus_wb_tag", wb_tag, 16'h0040);
    chk("plus_wb_val", wb_val, 16'h0101);
    step();
    chk("plus_one_cycle", wb_en, 0);
    issue(16'h2001, 16'h0007, 16'h0000, 0);
    chk("minus_wrap", wb_val, 16'hFFFF);
    issue(16'h5FFE, 0, 16'h0000, 16'h0010);
    chk("brz_taken", branch_en, 1);
    chk("brz_target", branch_target, 16'h000E);
    step();
    chk("brz_pulse", branch_en, 0);
    issue(16'h5FFE, 0, 16'h0005, 16'h0010);
    chk("brz_not_taken", branch_en, 0);
    chk("brz_no_wb", wb_en, 0);
    issue(16'h3123, 16'h0001, 16'h0001, 0);
    chk("undef_wb", wb_en, 0);
    chk("undef_stall", stall_out, 0);
    issue(16'h8000, 0, 16'h0141, 0);
    chk("print_valid", print_valid, 1);
    chk("print_data", print_data, 8'h41);
    chk("print_stall", stall_out, 1);
    ins = 16'h1005; ptr = 16'h0009; val = 16'h0001;
    repeat (3) begin
      step();
      chk("print_hold_stall", stall_out, 1);
      chk("print_hold_data", print_data, 8'h41);
      chk("print_hold_no_wb", wb_en, 0);
    end
    print_ready = 1;
    step();
    print_ready = 0;
    chk("print_done_stall", stall_out, 0);
    chk("print_done_valid", print_valid, 0);
    chk("held_not_yet", wb_en, 0);
    step();
    ins = 0;
    chk("held_wb_en", wb_en, 1);
    chk("held_wb_tag", wb_tag, 16'h0009);
    chk("held_wb_val", wb_val, 16'h0006);
    print_ready = 1;
    issue(16'h8000, 0, 16'h0042, 0);
    chk("fast_print_valid", print_valid, 1);
    chk("fast_print_data", print_data, 8'h42);
    ins = 16'h1001; ptr = 16'h0002; val = 16'h0000;
    step();
    print_ready = 0;
    chk("fast_stall_drop", stall_out, 0);
    step();
    ins = 0;
    chk("fast_accept", wb_en, 1);
    chk("fast_accept_val", wb_val, 16'h0001);
    issue(16'h8000, 0, 16'h0043, 0);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_valid", print_valid, 0);
    chk("rst_mid_stall", stall_out, 0);
`ifdef EXECUTE_RETIRE_CNT_EN
    chk("rst_mid_cnt", retired_cnt, 0);
`endif
    step();
    rst_n = 1;
    step();
    ins = 16'h1001; ptr = 16'h0003; val = 16'h0005;
    @(posedge clk);
    rst_n = 0;
    #1;
    ins = 0;
    chk("rst_edge_no_wb", wb_en, 0);
    step();
    rst_n = 1;
    step();
    for (int k = 0; k < 10; k++) begin
      issue(16'h1001, 16'(k), 16'(k * 3), 0);
      chk("b2b_wb_en", wb_en, 1);
      chk("b2b_wb_val", wb_val, 32'(k * 3 + 1));
    end
    step();
    chk("b2b_end", wb_en, 0);
`ifdef EXECUTE_RETIRE_CNT_EN
    chk("b2b_retired_cnt", retired_cnt, 10);
`endif
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
